// File: rtl/io_mailbox.sv
// io_mailbox: processor I/O word 255 bridged to a host valid/ready stream through TX and RX FIFOs.
// Full/empty decisions use registered counts only, so a same-cycle pop never makes room for a push.
module io_mailbox_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [31:0]       push_data,
  input  logic              pop,
  output logic [31:0]       head,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;
  always_comb begin
    full    = count == (ADDR_W+1)'(DEPTH);
    empty   = count == '0;
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    head    = mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

module io_mailbox #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wr_stb,
  input  logic [31:0]       cpu_wr_data,
  input  logic              cpu_rd_stb,
  output logic [31:0]       cpu_rd_data,
  output logic              host_tx_valid,
  output logic [31:0]       host_tx_data,
  input  logic              host_tx_ready,
  input  logic              host_rx_valid,
  input  logic [31:0]       host_rx_data,
  output logic              host_rx_ready,
  output logic [ADDR_W:0]   rx_count,
  output logic [ADDR_W:0]   tx_count,
  output logic              overflow,
  output logic              underflow
);
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [31:0] rx_head;
  io_mailbox_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_tx (
    .clk(clk), .rst(rst), .push(cpu_wr_stb), .push_data(cpu_wr_data),
    .pop(host_tx_ready), .head(host_tx_data), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );
  io_mailbox_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rx (
    .clk(clk), .rst(rst), .push(host_rx_valid), .push_data(host_rx_data),
    .pop(cpu_rd_stb), .head(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    host_tx_valid = ~tx_empty;
    host_rx_ready = ~rx_full;
    cpu_rd_data   = rx_empty ? 32'h0 : rx_head;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (cpu_wr_stb & tx_full);
      underflow <= underflow | (cpu_rd_stb & rx_empty);
    end
  end
endmodule

// File: tb/tb_io_mailbox.sv
// tb_io_mailbox: directed and randomized checks of io_mailbox against a queue-based reference.
module tb_io_mailbox;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_wr_stb = 1'b0, cpu_rd_stb = 1'b0;
  logic [31:0] cpu_wr_data = '0, cpu_rd_data;
  logic        host_tx_valid, host_tx_ready = 1'b0;
  logic [31:0] host_tx_data;
  logic        host_rx_valid = 1'b0, host_rx_ready;
  logic [31:0] host_rx_data = '0;
  logic [2:0]  rx_count, tx_count;
  logic        overflow, underflow;
  int          checks = 0, errors = 0;
  logic [31:0] txq[$], rxq[$];
  logic        ovf = 1'b0, unf = 1'b0;

  io_mailbox #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .cpu_wr_stb(cpu_wr_stb), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_stb(cpu_rd_stb), .cpu_rd_data(cpu_rd_data), .host_tx_valid(host_tx_valid),
    .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready), .host_rx_valid(host_rx_valid),
    .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready), .rx_count(rx_count),
    .tx_count(tx_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("tx_count", 32'(tx_count), 32'(txq.size()));
    chk("rx_count", 32'(rx_count), 32'(rxq.size()));
    chk("host_tx_valid", 32'(host_tx_valid), 32'(txq.size() != 0));
    chk("host_rx_ready", 32'(host_rx_ready), 32'(rxq.size() < 4));
    chk("cpu_rd_data", cpu_rd_data, rxq.size() != 0 ? rxq[0] : 32'h0);
    if (txq.size() != 0) chk("host_tx_data", host_tx_data, txq[0]);
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("underflow", 32'(underflow), 32'(unf));
  endtask

  task automatic step(input logic wr, input logic [31:0] wd, input logic rd,
                      input logic txr, input logic rxv, input logic [31:0] rxd);
    bit t_full, t_empty, r_full, r_empty;
    cpu_wr_stb = wr; cpu_wr_data = wd; cpu_rd_stb = rd;
    host_tx_ready = txr; host_rx_valid = rxv; host_rx_data = rxd;
    #1;
    check_outputs();
    t_full = txq.size() == 4; t_empty = txq.size() == 0;
    r_full = rxq.size() == 4; r_empty = rxq.size() == 0;
    @(posedge clk); #1;
    if (txr && !t_empty) void'(txq.pop_front());
    if (wr) begin
      if (t_full) ovf = 1'b1;
      else txq.push_back(wd);
    end
    if (rd) begin
      if (r_empty) unf = 1'b1;
      else void'(rxq.pop_front());
    end
    if (rxv && !r_full) rxq.push_back(rxd);
    cpu_wr_stb = 0; cpu_rd_stb = 0; host_tx_ready = 0; host_rx_valid = 0;
  endtask

  initial begin
    #2;
    chk("rst_tx_valid", 32'(host_tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(host_rx_ready), 32'h1);
    chk("rst_rd_data", cpu_rd_data, 32'h0);
    chk("rst_counts", {26'h0, tx_count, rx_count}, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    // 1: three stores held, then drained in order
    step(1, 32'h11, 0, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0, 0);
    step(1, 32'h33, 0, 0, 0, 0);
    chk("t1_count", 32'(tx_count), 32'd3);
    chk("t1_head", host_tx_data, 32'h11);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // 2: host pushes two words, processor reads one
    step(0, 0, 0, 0, 1, 32'hA5A5A5A5);
    step(0, 0, 0, 0, 1, 32'h5A5A5A5A);
    step(0, 0, 1, 0, 0, 0);
    chk("t2_data", cpu_rd_data, 32'h5A5A5A5A);
    chk("t2_count", 32'(rx_count), 32'd1);
    step(0, 0, 1, 0, 0, 0);
    // 3: five stores into a four-deep TX
    for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i), 0, 0, 0, 0);
    chk("t3_count", 32'(tx_count), 32'd4);
    chk("t3_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
    // 4: load on empty RX with a same-cycle host push
    step(0, 0, 1, 0, 1, 32'hCAFE0004);
    chk("t4_unf", 32'(underflow), 32'h1);
    chk("t4_count", 32'(rx_count), 32'd1);
    chk("t4_data", cpu_rd_data, 32'hCAFE0004);
    step(0, 0, 1, 0, 0, 0);
    // 5: streaming push+pop every cycle across pointer wrap
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 1, $urandom);
    for (int i = 0; i < 12; i++) step(1, $urandom, 1, 1, 1, $urandom);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    // 6: async reset with two TX words in flight
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
    step(1, 32'hD0, 0, 0, 0, 0);
    step(1, 32'hD1, 0, 0, 0, 0);
    chk("t6_pre", 32'(tx_count), 32'd2);
    host_tx_ready = 1'b1;
    #2; rst = 1'b0; #1;
    chk("t6_valid", 32'(host_tx_valid), 32'h0);
    chk("t6_counts", {26'h0, tx_count, rx_count}, 32'h0);
    chk("t6_flags", {30'h0, overflow, underflow}, 32'h0);
    txq.delete(); rxq.delete(); ovf = 1'b0; unf = 1'b0; host_tx_ready = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    chk("t6_rx_ready", 32'(host_rx_ready), 32'h1);
    for (int i = 0; i < 40; i++)
      step(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
